bcd_mod_counter: RTL

- Parametrised cascaded-BCD modulus counter for the timekeeping datapath (seconds/minutes/hours and similar).
- Counts up or down modulo MODULUS across DIGITS BCD decades.
- Provides BCD digits, a lockstep binary value, a terminal-count carry/borrow for cascading, synchronous clear and validated parallel load.
- Default configuration is a mod-60, two-digit counter; chaining instances through co/en builds clock chains.

---
 rtl/bcd_mod_counter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - cascaded BCD modulus counter with lockstep binary value
//
// Purpose: counts up or down modulo MODULUS across DIGITS BCD decades. It keeps
// a binary copy of the count in lockstep, drives a terminal-count pulse for
// chaining, and supports synchronous clear and a validated parallel load.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-low reset
//   i_clr        synchronous clear to 0 (highest priority)
//   i_en         count enable, one step per enabled cycle
//   i_up         direction, 1 = increment, 0 = decrement
//   i_load       synchronous parallel load request
//   i_load_bcd   load value, digit i at [4i+3:4i], digit 0 = units
//   o_bcd        current count as BCD digits, same packing as i_load_bcd
//   o_bin        current count as binary, always equal to decimal(o_bcd)
//   o_co         terminal-count pulse (combinational) for the next stage
//   o_load_err   one-cycle flag: the previous cycle's load was rejected

module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60,
  localparam int BW     = $clog2(MODULUS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic                i_up,
  input  logic                i_load,
  input  logic [4*DIGITS-1:0] i_load_bcd,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic [BW-1:0]       o_bin,
  output logic                o_co,
  output logic                o_load_err
);

  localparam int MAX_MOD = 10 ** DIGITS;

  if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > MAX_MOD) begin : g_param_check
    $error("bcd_mod_counter: DIGITS must be 1..4 and MODULUS 2..10**DIGITS");
  end

  function automatic logic [4*DIGITS-1:0] f_to_bcd(input int v);
    logic [4*DIGITS-1:0] res;
    int                  t;
    res = '0;
    t   = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t             = t / 10;
    end
    return res;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = f_to_bcd(MODULUS - 1);
  localparam logic [BW-1:0]       MAX_BIN = BW'(MODULUS - 1);
  localparam logic [BW-1:0]       BIN_ONE = BW'(1);
  // Wide enough for the largest 4-digit load value (9999).
  localparam logic [13:0]         MOD_W   = 14'(MODULUS);

  logic [4*DIGITS-1:0] r_bcd;
  logic [BW-1:0]       r_bin;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_bcd_inc;
  logic [4*DIGITS-1:0] w_bcd_dec;
  logic [13:0]         w_load_val;
  logic                w_load_ok;
  logic                w_at_max;
  logic                w_at_zero;

  assign w_at_max  = (r_bcd == MAX_BCD);
  assign w_at_zero = (r_bcd == '0);

  // Digit-wise ripple increment: 9 rolls to 0 and carries upward.
  always_comb begin
    logic v_carry;
    w_bcd_inc = r_bcd;
    v_carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_carry) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          v_carry             = 1'b0;
        end
      end
    end
  end

  // Digit-wise ripple decrement: 0 rolls to 9 and borrows upward.
  always_comb begin
    logic v_borrow;
    w_bcd_dec = r_bcd;
    v_borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_borrow) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          v_borrow            = 1'b0;
        end
      end
    end
  end

  // Load validation and BCD-to-binary conversion (Horner, most significant
  // digit first). The value is only meaningful when every digit is legal.
  always_comb begin
    logic v_digits_ok;
    w_load_val  = '0;
    v_digits_ok = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i_load_bcd[4*i +: 4] > 4'd9) begin
        v_digits_ok = 1'b0;
      end
      w_load_val = 14'(w_load_val * 14'd10) + {10'd0, i_load_bcd[4*i +: 4]};
    end
    w_load_ok = v_digits_ok && (w_load_val < MOD_W);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      r_load_err <= 1'b0;
    end else if (i_clr) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      r_load_err <= 1'b0;
    end else if (i_load) begin
      if (w_load_ok) begin
        r_bcd      <= i_load_bcd;
        r_bin      <= w_load_val[BW-1:0];
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
    end else if (i_en && i_up) begin
      r_load_err <= 1'b0;
      // Modulus wrap overrides the natural BCD ripple.
      if (w_at_max) begin
        r_bcd <= '0;
        r_bin <= '0;
      end else begin
        r_bcd <= w_bcd_inc;
        r_bin <= r_bin + BIN_ONE;
      end
    end else if (i_en) begin
      r_load_err <= 1'b0;
      if (w_at_zero) begin
        r_bcd <= MAX_BCD;
        r_bin <= MAX_BIN;
      end else begin
        r_bcd <= w_bcd_dec;
        r_bin <= r_bin - BIN_ONE;
      end
    end else begin
      r_load_err <= 1'b0;
    end
  end

  // Same-cycle terminal count so a downstream stage advances on this edge.
  assign o_co       = i_rst & i_en & (i_up ? w_at_max : w_at_zero);
  assign o_bcd      = r_bcd;
  assign o_bin      = r_bin;
  assign o_load_err = r_load_err;

endmodule
